// File: rtl/seq_restoring_divider_if.sv
// Handshake and data bundle for the sequential restoring divider.
// The master drives a request and operands; the slave returns status and results.
interface seq_restoring_divider_if #(
    parameter int N = 2
);
    logic             start;
    logic [2*N-1:0]   dividend;
    logic [N-1:0]     divisor;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [2*N-1:0]   quotient;
    logic [N-1:0]     remainder;

    modport master (
        output start, dividend, divisor,
        input  busy, done, div_by_zero, quotient, remainder
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, div_by_zero, quotient, remainder
    );
endinterface

// File: rtl/seq_restoring_divider.sv
// Iterative radix-2 restoring divider: 2N-bit dividend / N-bit divisor,
// one quotient bit per cycle, results held until the next completion.
module seq_restoring_divider #(
    parameter int N = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seq_restoring_divider_if.slave bus
);
    localparam int CNT_W = $clog2(2 * N + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [N-1:0]     r_div;
    logic [N:0]       r_rem;
    logic [2*N-1:0]   r_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;
    logic [2*N-1:0]   r_quot;
    logic [N-1:0]     r_remo;

    logic [N:0]       w_r_sh;
    logic [2*N-1:0]   w_q_sh;
    logic [N+1:0]     w_t;
    logic [N:0]       w_r_next;
    logic [2*N-1:0]   w_q_next;
    logic             w_last;

    // One restoring step: shift {R,Q} left, trial-subtract, keep or restore.
    // R stays below the divisor, so the bit shifted out of R's MSB is always 0.
    always_comb begin
        w_r_sh   = {r_rem[N-1:0], r_q[2*N-1]};
        w_q_sh   = {r_q[2*N-2:0], 1'b0};
        w_t      = {1'b0, w_r_sh} - {2'b00, r_div};
        w_r_next = w_r_sh;
        w_q_next = w_q_sh;
        if (w_t[N+1] == 1'b0) begin
            w_r_next = w_t[N:0];
            w_q_next = {w_q_sh[2*N-1:1], 1'b1};
        end else begin
            w_r_next = w_r_sh;
            w_q_next = w_q_sh;
        end
        w_last = (r_cnt == CNT_W'(2 * N - 1));
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_div   <= {N{1'b0}};
            r_rem   <= {(N+1){1'b0}};
            r_q     <= {(2*N){1'b0}};
            r_cnt   <= {CNT_W{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
            r_quot  <= {(2*N){1'b0}};
            r_remo  <= {N{1'b0}};
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_div <= bus.divisor;
                        r_rem <= {(N+1){1'b0}};
                        r_q   <= bus.dividend;
                        r_cnt <= {CNT_W{1'b0}};
                        if (bus.divisor == {N{1'b0}}) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_quot  <= {(2*N){1'b1}};
                            r_remo  <= {N{1'b0}};
                            r_dbz   <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_rem <= w_r_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_quot  <= w_q_next;
                        r_remo  <= w_r_next[N-1:0];
                        r_dbz   <= 1'b0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_DONE;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;
    assign bus.quotient    = r_quot;
    assign bus.remainder   = r_remo;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (N=2) using a result scoreboard.
module tb_seq_restoring_divider;
    localparam int N = 2;

    typedef struct {
        logic [3:0] q;
        logic [1:0] r;
        logic       z;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb[$];

    seq_restoring_divider_if #(.N(N)) bus ();

    seq_restoring_divider #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            if (bus.busy === 1'b1 && bus.done === 1'b1) begin
                errors++;
                $display("FAIL busy_done_overlap busy=%b done=%b required not both high", bus.busy, bus.done);
            end
            if (bus.done === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done got done=1 required no completion pending");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (bus.quotient !== e.q || bus.remainder !== e.r || bus.div_by_zero !== e.z) begin
                        errors++;
                        $display("FAIL result got q=%0d r=%0d z=%b required q=%0d r=%0d z=%b",
                                 bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.z);
                    end
                end
            end
        end
    end

    function automatic exp_t model(input logic [3:0] dd, input logic [1:0] dv);
        exp_t e;
        if (dv == 2'd0) begin
            e.q = 4'hF; e.r = 2'd0; e.z = 1'b1;
        end else begin
            e.q = 4'(int'(dd) / int'(dv));
            e.r = 2'(int'(dd) % int'(dv));
            e.z = 1'b0;
        end
        return e;
    endfunction

    // Issue one operation and measure cycles from accept to done (bounded).
    task automatic do_op(input logic [3:0] dd, input logic [1:0] dv, output int lat);
        sb.push_back(model(dd, dv));
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = dd; bus.divisor = dv;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.start = 1'b0; bus.dividend = 4'd0; bus.divisor = 2'd0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_by_zero !== 1'b0 ||
            bus.quotient !== 4'd0 || bus.remainder !== 2'd0) begin
            errors++;
            $display("FAIL reset_state got busy=%b done=%b z=%b q=%0d r=%0d required all 0",
                     bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        sb.push_back(model(4'd9, 2'd2));
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 4'd9; bus.divisor = 2'd2;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                errors++;
                $display("FAIL basic_busy cycle=%0d got busy=%b done=%b required busy=1 done=0", c, bus.busy, bus.done);
            end
            @(negedge clk);
        end
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.quotient !== 4'd4 || bus.remainder !== 2'd1) begin
            errors++;
            $display("FAIL basic_done got done=%b busy=%b q=%0d r=%0d required done=1 busy=0 q=4 r=1",
                     bus.done, bus.busy, bus.quotient, bus.remainder);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.quotient !== 4'd4) begin
            errors++;
            $display("FAIL basic_pulse got done=%b q=%0d required done=0 q=4", bus.done, bus.quotient);
        end
    endtask

    task automatic test_sweep();
        int lat;
        for (int dd = 0; dd < 16; dd++) begin
            for (int dv = 1; dv < 4; dv++) begin
                do_op(4'(dd), 2'(dv), lat);
                checks++;
                if (lat != 5) begin
                    errors++;
                    $display("FAIL sweep_latency %0d/%0d got %0d required 5", dd, dv, lat);
                end
            end
        end
    endtask

    task automatic test_roundtrip();
        int lat;
        for (int a = 1; a < 4; a++) begin
            for (int b = 1; b < 4; b++) begin
                sb.push_back('{q: 4'(a), r: 2'd0, z: 1'b0});
                @(negedge clk);
                bus.start = 1'b1; bus.dividend = 4'(a * b); bus.divisor = 2'(b);
                @(negedge clk);
                bus.start = 1'b0;
                lat = 1;
                while (bus.done !== 1'b1 && lat < 20) begin
                    @(negedge clk);
                    lat++;
                end
                checks++;
                if (lat != 5) begin
                    errors++;
                    $display("FAIL roundtrip_latency a=%0d b=%0d got %0d required 5", a, b, lat);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_div_zero();
        int lat;
        do_op(4'b0110, 2'd0, lat);
        checks++;
        if (lat != 1) begin
            errors++;
            $display("FAIL dbz_latency got %0d required 1", lat);
        end
        sb.push_back(model(4'd15, 2'd3));
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 4'd15; bus.divisor = 2'd3;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.quotient !== 4'hF || bus.div_by_zero !== 1'b1 || bus.remainder !== 2'd0) begin
            errors++;
            $display("FAIL dbz_hold got busy=%b q=%0d z=%b r=%0d required busy=1 q=15 z=1 r=0",
                     bus.busy, bus.quotient, bus.div_by_zero, bus.remainder);
        end
        lat = 1;
        while (bus.done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 5 || bus.div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL dbz_clear got lat=%0d z=%b required lat=5 z=0", lat, bus.div_by_zero);
        end
        @(negedge clk);
    endtask

    task automatic test_edges();
        int lat;
        do_op(4'd15, 2'd1, lat);
        do_op(4'd0, 2'd3, lat);
        do_op(4'd2, 2'd3, lat);
        checks++;
        if (bus.quotient !== 4'd0 || bus.remainder !== 2'd2) begin
            errors++;
            $display("FAIL edge_hold got q=%0d r=%0d required q=0 r=2", bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_back_to_back();
        int rises[$];
        logic prev_busy;
        prev_busy = 1'b0;
        sb.push_back(model(4'd13, 2'd3));
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 4'd13; bus.divisor = 2'd3;
        for (int cyc = 1; cyc <= 18; cyc++) begin
            @(negedge clk);
            if (bus.busy === 1'b1 && prev_busy === 1'b0) rises.push_back(cyc);
            prev_busy = bus.busy;
            if (cyc == 2) begin
                bus.dividend = 4'd7; bus.divisor = 2'd2;
                sb.push_back(model(4'd7, 2'd2));
            end
            if (cyc == 8) begin
                bus.dividend = 4'd10; bus.divisor = 2'd3;
                sb.push_back(model(4'd10, 2'd3));
            end
            if (cyc == 17) bus.start = 1'b0;
        end
        checks++;
        if (rises.size() != 3 || rises[0] != 1 || rises[1] != 7 || rises[2] != 13) begin
            errors++;
            $display("FAIL b2b_accepts got %0d accepts first=%0d required 3 accepts at cycles 1,7,13",
                     rises.size(), (rises.size() > 0) ? rises[0] : -1);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int lat;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 4'd11; bus.divisor = 2'd2;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quotient !== 4'd0 ||
            bus.remainder !== 2'd0 || bus.div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset got busy=%b done=%b q=%0d r=%0d z=%b required all 0",
                     bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        do_op(4'd14, 2'd3, lat);
        checks++;
        if (lat != 5 || bus.quotient !== 4'd4 || bus.remainder !== 2'd2) begin
            errors++;
            $display("FAIL after_reset got lat=%0d q=%0d r=%0d required lat=5 q=4 r=2", lat, bus.quotient, bus.remainder);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_sweep();
        test_roundtrip();
        test_div_zero();
        test_edges();
        test_back_to_back();
        test_reset_mid_run();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Iterative radix-2 restoring divider, the inverse of the team's N x N combinational multipliers.
- Takes a 2N-bit dividend (product-width) and an N-bit divisor, and returns a 2N-bit quotient and an N-bit remainder after a fixed number of cycles.
- Used as the round-trip checker and the inverse datapath for multiplier candidates: feeding in P and B of a correct multiplier must return A with remainder 0.

Parameters:
- N, 2, divisor/remainder width; dividend/quotient width is 2N.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- start  input  1  request; accepted only when state is IDLE.
- dividend  input  2N  numerator, unsigned, sampled on the accepting edge.
- divisor  input  N  denominator, unsigned, sampled on the accepting edge.
- busy  output  1  high while state is RUN.
- done  output  1  one-cycle pulse; quotient/remainder valid from this cycle on.
- div_by_zero  output  1  set with done when the divisor was 0; held until next completion.
- quotient  output  2N  unsigned floor(dividend/divisor).
- remainder  output  N  unsigned dividend mod divisor.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at an edge):
  - state goes to IDLE;
  - busy=0, done=0, div_by_zero=0, quotient=0, remainder=0;
  - internal counter and working registers are cleared.
  - Reset overrides everything, including mid-RUN: the operation is aborted with no done.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at an edge:
  - latch the divisor;
  - working remainder R (N+1 bits) = 0;
  - working quotient/shift register Q = dividend;
  - iteration counter = 0;
  - next state is RUN, or DONE if divisor==0.
- IDLE, start=0: hold.
- RUN, each edge performs one iteration:
  - shift {R,Q} left by 1;
  - T = R - {0,divisor};
  - if T >= 0: R = T, Q[0] = 1; else Q[0] = 0 (restore);
  - counter increments.
  - On the edge completing iteration 2N: register quotient=Q and remainder=R[N-1:0], div_by_zero=0, next state is DONE.
- Divide by zero: skip RUN; on entering DONE set quotient=all ones, remainder=0, div_by_zero=1.
- DONE: done=1 for exactly this cycle; next edge goes to IDLE unconditionally.
- Start handling:
  - start in RUN or DONE is ignored, not queued;
  - operand changes while busy have no effect.
- Latency (start accepting edge to done high):
  - 2N+1 clock cycles; 5 for N=2.
  - Divide by zero: 1 cycle.
- Back-to-back: the earliest next accept is the edge after DONE (IDLE cycle), so throughput is one result per 2N+2 cycles.
- Output hold: quotient, remainder and div_by_zero hold the last result through IDLE and RUN; they change only on entry to DONE or on reset.
- Width rules:
  - R is N+1 bits internally, so the subtraction never overflows.
  - Quotient can equal the full 2N-bit value (divisor=1).
  - Remainder is always < divisor.
- done and busy are never both high.

Test Plan:
- Reset, then dividend=4'b1001 (9), divisor=2'b10 (2), start pulse -> busy high 4 cycles, done on cycle 5, quotient=4, remainder=1, div_by_zero=0.
- Exhaustive N=2 sweep: all 16 dividends x 3 nonzero divisors, each checked against floor/mod. Round-trip: for all A,B in 1..3, dividend=A*B and divisor=B -> quotient=A, remainder=0.
- divisor=0, dividend=4'b0110 -> done 1 cycle after accept, quotient=4'b1111, remainder=0, div_by_zero=1. A following valid op (15/3) -> quotient=5, remainder=0, div_by_zero cleared.
- Edge values: 15/1 -> quotient=15, remainder=0; 0/3 -> quotient=0, remainder=0; 2/3 -> quotient=0, remainder=2.
- start held high continuously, with operands changed mid-RUN -> results correspond only to the operands latched at each accept. Accepts are spaced 2N+2=6 cycles apart, and no start is accepted in RUN or DONE.
- rst_n=0 on cycle 2 of RUN -> busy=0 next cycle, no done pulse, outputs=0. A new start after reset completes correctly (e.g. 14/3 -> quotient=4, remainder=2).
